// File: rtl/census_wta_controller_pkg.sv
// Shared definitions for the census winner-take-all controller: FSM encoding,
// default parameters and a constant clog2 helper.
package census_wta_controller_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MAX_DISP   = 16;
    localparam int DEF_PC_LATENCY = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int f_clog2(input int value);
        int r_bits;
        int r_rem;
        r_bits = 0;
        r_rem  = value - 1;
        while (r_rem > 0) begin
            r_bits = r_bits + 1;
            r_rem  = r_rem >> 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/census_wta_controller_pop_count.sv
// Pipelined population count: input in cycle c appears on outp in cycle
// c+LATENCY. Pipe contents are cleared by rst.
module pop_count
    import census_wta_controller_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  LATENCY = DEF_PC_LATENCY,
    localparam int OUT_W   = f_clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    output logic [OUT_W-1:0] outp
);

    logic [OUT_W-1:0] w_sum;
    logic [OUT_W-1:0] r_pipe [LATENCY];

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum = w_sum + OUT_W'(inp[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_sum;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign outp = r_pipe[LATENCY-1];

endmodule

// File: rtl/census_wta_controller.sv
// Issues left^right[d] for every disparity into one shared pop_count, tags each
// issue, and keeps the minimum-cost disparity as tagged results return.
module census_wta_controller
    import census_wta_controller_pkg::*;
#(
    parameter int  WIDTH      = DEF_WIDTH,
    parameter int  MAX_DISP   = DEF_MAX_DISP,
    parameter int  PC_LATENCY = DEF_PC_LATENCY,
    localparam int DISP_W     = f_clog2(MAX_DISP),
    localparam int COST_W     = f_clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          left,
    input  logic [WIDTH*MAX_DISP-1:0] right,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DISP_W-1:0]         best_disp,
    output logic [COST_W-1:0]         best_cost,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam logic [DISP_W-1:0] LAST_D = DISP_W'(MAX_DISP - 1);

    state_t                    r_state;
    logic [DISP_W-1:0]         r_d;
    logic [WIDTH-1:0]          r_left;
    logic [WIDTH*MAX_DISP-1:0] r_right;
    logic                      r_out_valid;
    logic [DISP_W-1:0]         r_best_disp;
    logic [COST_W-1:0]         r_best_cost;
    logic [PC_LATENCY-1:0]     r_tag_vld;
    logic [DISP_W-1:0]         r_tag [PC_LATENCY];

    logic [WIDTH-1:0]          w_cand [MAX_DISP];
    logic [WIDTH-1:0]          w_pc_in;
    logic [COST_W-1:0]         w_pc_out;
    logic                      w_tail_vld;
    logic [DISP_W-1:0]         w_tail_tag;
    logic                      w_take;

    for (genvar g = 0; g < MAX_DISP; g++) begin : g_cand
        assign w_cand[g] = r_right[g*WIDTH +: WIDTH];
    end

    // Idle issue slots feed zero so the pop_count pipe holds no stale data.
    assign w_pc_in = (r_state == S_ISSUE) ? (r_left ^ w_cand[r_d]) : '0;

    pop_count #(
        .WIDTH   (WIDTH),
        .LATENCY (PC_LATENCY)
    ) u_pop_count (
        .clk  (clk),
        .rst  (rst),
        .inp  (w_pc_in),
        .outp (w_pc_out)
    );

    assign w_tail_vld = r_tag_vld[PC_LATENCY-1];
    assign w_tail_tag = r_tag[PC_LATENCY-1];
    // Strict less-than: on a tie the earlier (lower) disparity is kept.
    assign w_take     = w_tail_vld &&
                        ((w_tail_tag == '0) || (w_pc_out[COST_W-1:0] < r_best_cost));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_out_valid <= 1'b0;
            r_best_disp <= '0;
            r_best_cost <= '0;
            r_tag_vld   <= '0;
            for (int i = 0; i < PC_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= (r_state == S_ISSUE);
            r_tag[0]     <= r_d;
            for (int i = 1; i < PC_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag[i]     <= r_tag[i-1];
            end

            if (w_take) begin
                r_best_disp <= w_tail_tag;
                r_best_cost <= w_pc_out[COST_W-1:0];
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_left  <= left;
                        r_right <= right;
                        r_d     <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_d == LAST_D) begin
                        r_d     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_d <= r_d + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_tail_vld && (w_tail_tag == LAST_D)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; neither side may depend on the other's ready to raise valid.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign best_disp = r_best_disp;
    assign best_cost = r_best_cost;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule
